led_status_manager: RTL and testbench
=====================================

Name: led_status_manager

Overview:
- Parametrised successor to the board LED manager: one clock domain; N error channels; sticky latched flags with blink-on-new-error; debug data view; config-notification field.
- Sits between the UART/config-manager status outputs and the board LED pins.
- All inputs are already synchronous to clk; there are no VGA or UART clocks in this block.

Parameters:
- NUM_LEDS, 16, total LED outputs.
- NUM_ERR_CH, 6, error channels (default: 4 config-manager plus 2 UART).
- DATA_W, 8, width of the debug data byte.
- CFG_W, 8, width of the config-notification field.
- BLINK_HALF, 25000000, cycles per blink half-period.
- HOLD_CYC, 150000000, cycles a channel blinks after a new error before going steady.
- Legal configurations: NUM_ERR_CH+CFG_W <= NUM_LEDS and DATA_W < NUM_LEDS; otherwise elaboration fails.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- debug_sel  in  1  1 = debug view, 0 = status view.
- data  in  DATA_W  debug data byte.
- data_valid  in  1  single-cycle qualifier for data.
- err  in  NUM_ERR_CH  error vector, one bit per channel.
- err_valid  in  1  qualifier for err.
- err_clear  in  1  single-cycle pulse; clears all sticky flags.
- cfg  in  CFG_W  config-notification level.
- leds  out  NUM_LEDS  registered LED drive.

Behaviour:
- Reset (rst=0, async): all state registers cleared. leds=0, data_reg=0, cfg_reg=0, prescaler=0, phase=0, all channels OFF, all hold counters 0.
- Prescaler: free-running; counts 0..BLINK_HALF-1; phase toggles on wrap. The first phase after reset is 0, so LEDs start dark.
- data_reg loads data on a clk edge where data_valid=1, in either mode. cfg_reg samples cfg every cycle.
- Per-channel FSM (states OFF, BLINK, ON):
  - OFF -> BLINK when err_valid and err[i]; hold counter loads HOLD_CYC-1.
  - BLINK: hold counter decrements each cycle; at 0 -> ON.
  - BLINK or ON, with a new err_valid and err[i]: go to BLINK and reload the hold counter (restart).
  - Any state -> OFF on err_clear. err_clear has priority over a simultaneous error on the same edge.
  - err bits with err_valid=0 are ignored.
- Channel LED value: OFF=0, BLINK=phase, ON=1.
- Status view (debug_sel=0):
  - leds[NUM_ERR_CH-1:0] = channel values.
  - leds[NUM_LEDS-1 -: CFG_W] = cfg_reg.
  - Remaining middle bits = 0.
- Debug view (debug_sel=1):
  - leds[DATA_W-1:0] = data_reg.
  - leds[NUM_LEDS-1] = OR of all channels not OFF.
  - Remaining bits = 0.
- Latency:
  - Input sampled at edge k updates state at k; leds reflect it at edge k+1.
  - A debug_sel change is visible at the next edge.
- Channel state and data_reg are retained across mode switches.
- Reset asserted mid-blink forces all outputs to 0 immediately, with no glitch-back.

Optional Feature:
- Macro: LED_DIM_EN.
- When defined:
  - Adds parameter DIM_DUTY (default 4, range 0..15) and a free-running 4-bit PWM counter.
  - ON-state channel LEDs and cfg LEDs output 1 only while pwm_cnt < DIM_DUTY.
  - BLINK-state LEDs stay at full brightness, so a new error is distinguishable.
  - Debug data bits are not dimmed.
- When undefined: no PWM logic is present, and ON drives a constant 1.

Decomposition:
- Package led_mgr_pkg:
  - chan_state_t enum: OFF=2'b00, BLINK=2'b01, ON=2'b10.
  - MODE_STATUS and MODE_DEBUG constants.
  - PWM_W=4.
- Sub-module led_err_channel, instantiated NUM_ERR_CH times via generate:
  - Inputs: set, clear, phase.
  - Contains: FSM and hold counter.
  - Output: led bit and an active flag.
- The top level holds the prescaler, data/cfg registers, view mux and output register.

Test Plan (bench parameters BLINK_HALF=4, HOLD_CYC=16):
- Reset held 10 cycles, then released -> leds=16'h0000; the first 4 cycles after release stay 0 with no stimulus.
- err=6'b000001, err_valid for 1 cycle, debug_sel=0 -> leds[0] toggles every 4 cycles for 16 cycles, then steady 1; leds[5:1]=0.
- After 8 cycles of blinking, a second error on channel 0 -> blink restarts and lasts 16 more cycles. Then err_clear with err=6'b000001, err_valid=1 on the same edge -> leds[0]=0 next edge.
- cfg=8'h81 -> leds[15:8]=8'h81 at edge k+1. Then debug_sel=1, data=8'hAA, data_valid=1 -> leds=16'h80AA while channel 0 is active, 16'h00AA after clear.
- err=6'b110100 with err_valid=0 -> no LED change. With err_valid=1 -> channels 2, 4 and 5 blink in phase.
- LED_DIM_EN defined, DIM_DUTY=4, channel in ON -> its LED is high 4 of every 16 cycles; a BLINK channel is unaffected.

Source files
------------

// File: rtl/led_status_manager_pkg.sv
// Shared types and constants for the board LED status manager and its error channels.
// Optional build macro: LED_DIM_EN (PWM dimming of steady LEDs).
package led_mgr_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        BLINK = 2'b01,
        ON    = 2'b10
    } chan_state_t;

    localparam logic MODE_STATUS = 1'b0;
    localparam logic MODE_DEBUG  = 1'b1;
    localparam int   PWM_W       = 4;

endpackage

// File: rtl/led_err_channel.sv
// One sticky error channel: blinks for HOLD_CYC cycles after each new error, then stays lit.
// Optional build macro: LED_DIM_EN adds the dim_on gate applied to the steady state.
module led_err_channel
    import led_mgr_pkg::*;
#(
    parameter int HOLD_CYC = 150000000
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clear,
    input  logic phase,
`ifdef LED_DIM_EN
    input  logic dim_on,
`endif
    output logic led,
    output logic active
);

    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

    chan_state_t   state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;

    // Next state: clear beats a simultaneous set; a set always restarts the blink window.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (clear) begin
            state_d = OFF;
            hold_d  = {HW{1'b0}};
        end else if (set) begin
            state_d = BLINK;
            hold_d  = HOLD_LOAD;
        end else begin
            case (state_q)
                OFF:   state_d = OFF;
                BLINK: begin
                    if (hold_q == {HW{1'b0}}) begin
                        state_d = ON;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                ON:    state_d = ON;
                default: begin
                    state_d = OFF;
                    hold_d  = {HW{1'b0}};
                end
            endcase
        end
    end

    // State and hold counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OFF;
            hold_q  <= {HW{1'b0}};
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // LED value for this channel; the top level registers it.
    always_comb begin
        led    = 1'b0;
        active = (state_q != OFF);
        case (state_q)
            OFF:   led = 1'b0;
            BLINK: led = phase;
`ifdef LED_DIM_EN
            ON:    led = dim_on;
`else
            ON:    led = 1'b1;
`endif
            default: led = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_status_manager.sv
// Board LED manager: sticky per-channel error flags with blink-on-new-error, cfg field and debug byte view.
// Optional build macro: LED_DIM_EN (adds DIM_DUTY and PWM dimming of steady channel and cfg LEDs).
module led_status_manager
    import led_mgr_pkg::*;
#(
    parameter int NUM_LEDS   = 16,
    parameter int NUM_ERR_CH = 6,
    parameter int DATA_W     = 8,
    parameter int CFG_W      = 8,
    parameter int BLINK_HALF = 25000000,
    parameter int HOLD_CYC   = 150000000
`ifdef LED_DIM_EN
    ,
    parameter int DIM_DUTY   = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  debug_sel,
    input  logic [DATA_W-1:0]     data,
    input  logic                  data_valid,
    input  logic [NUM_ERR_CH-1:0] err,
    input  logic                  err_valid,
    input  logic                  err_clear,
    input  logic [CFG_W-1:0]      cfg,
    output logic [NUM_LEDS-1:0]   leds
);

    if ((NUM_ERR_CH + CFG_W > NUM_LEDS) || (DATA_W >= NUM_LEDS)) begin : g_bad_cfg
        $error("led_status_manager: channel/cfg/data fields do not fit in NUM_LEDS");
    end
`ifdef LED_DIM_EN
    if ((DIM_DUTY < 0) || (DIM_DUTY > 15)) begin : g_bad_duty
        $error("led_status_manager: DIM_DUTY must be 0..15");
    end
`endif

    localparam int PW = $clog2(BLINK_HALF + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_HALF - 1);

    logic [PW-1:0]         pre_q, pre_d;
    logic                  phase_q, phase_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic [NUM_LEDS-1:0]   leds_q, leds_d;
    logic [NUM_ERR_CH-1:0] chan_led, chan_active;
    logic                  dim_on;

`ifdef LED_DIM_EN
    logic [PWM_W-1:0] pwm_q, pwm_d;

    // Free-running PWM counter for dimming steady LEDs.
    always_comb begin
        pwm_d  = pwm_q + PWM_W'(1);
        dim_on = (pwm_q < PWM_W'(DIM_DUTY));
    end

    // PWM counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_q <= {PWM_W{1'b0}};
        end else begin
            pwm_q <= pwm_d;
        end
    end
`else
    assign dim_on = 1'b1;
`endif

    // Blink prescaler, debug byte capture and cfg sampling.
    always_comb begin
        if (pre_q == PRE_LAST) begin
            pre_d   = {PW{1'b0}};
            phase_d = ~phase_q;
        end else begin
            pre_d   = pre_q + PW'(1);
            phase_d = phase_q;
        end
        if (data_valid) begin
            data_d = data;
        end else begin
            data_d = data_q;
        end
        cfg_d = cfg;
    end

    for (genvar i = 0; i < NUM_ERR_CH; i++) begin : g_chan
        led_err_channel #(
            .HOLD_CYC (HOLD_CYC)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .set    (err_valid & err[i]),
            .clear  (err_clear),
            .phase  (phase_q),
`ifdef LED_DIM_EN
            .dim_on (dim_on),
`endif
            .led    (chan_led[i]),
            .active (chan_active[i])
        );
    end

    // View mux: debug_sel is used unregistered so a mode change lands on the next edge.
    always_comb begin
        leds_d = {NUM_LEDS{1'b0}};
        if (debug_sel == MODE_STATUS) begin
            leds_d[NUM_ERR_CH-1:0]      = chan_led;
            leds_d[NUM_LEDS-1 -: CFG_W] = cfg_q & {CFG_W{dim_on}};
        end else begin
            leds_d[DATA_W-1:0]  = data_q;
            leds_d[NUM_LEDS-1]  = |chan_active;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= {PW{1'b0}};
            phase_q <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
            cfg_q   <= {CFG_W{1'b0}};
            leds_q  <= {NUM_LEDS{1'b0}};
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            data_q  <= data_d;
            cfg_q   <= cfg_d;
            leds_q  <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_led_status_manager.sv
// Self-checking bench for led_status_manager: directed steps plus random traffic against an age-based model.
module tb_led_status_manager;

    localparam int BH = 4;
    localparam int HC = 16;

    logic        clk;
    logic        rst;
    logic        debug_sel;
    logic [7:0]  data;
    logic        data_valid;
    logic [5:0]  err;
    logic        err_valid;
    logic        err_clear;
    logic [7:0]  cfg;
    logic [15:0] leds;

    int errors = 0;
    int checks = 0;

    // Reference model: edges since reset, per-channel edge of last new error, sticky flags.
    int         n_m;
    int         set_e [6];
    logic [5:0] act_m;
    logic [7:0] data_m;
    logic [7:0] cfg_m;

    led_status_manager #(
        .NUM_LEDS   (16),
        .NUM_ERR_CH (6),
        .DATA_W     (8),
        .CFG_W      (8),
        .BLINK_HALF (BH),
        .HOLD_CYC   (HC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .debug_sel  (debug_sel),
        .data       (data),
        .data_valid (data_valid),
        .err        (err),
        .err_valid  (err_valid),
        .err_clear  (err_clear),
        .cfg        (cfg),
        .leds       (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_view(input logic dsel);
        logic [15:0] v;
        logic        ph;
        logic        on_v;
        v  = 16'h0000;
        ph = ((n_m / BH) % 2) == 1;
`ifdef LED_DIM_EN
        on_v = (n_m % 16) < 4;
`else
        on_v = 1'b1;
`endif
        if (dsel) begin
            v[7:0] = data_m;
            v[15]  = |act_m;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!act_m[i])                   v[i] = 1'b0;
                else if ((n_m - set_e[i]) < HC)  v[i] = ph;
                else                             v[i] = on_v;
            end
            v[15:8] = cfg_m & {8{on_v}};
        end
        return v;
    endfunction

    task automatic model_reset();
        n_m    = 0;
        act_m  = 6'b000000;
        data_m = 8'h00;
        cfg_m  = 8'h00;
        for (int i = 0; i < 6; i++) set_e[i] = 0;
    endtask

    task automatic model_edge();
        n_m++;
        if (err_clear) begin
            act_m = 6'b000000;
        end else if (err_valid) begin
            for (int i = 0; i < 6; i++) begin
                if (err[i]) begin
                    act_m[i] = 1'b1;
                    set_e[i] = n_m;
                end
            end
        end
        if (data_valid) data_m = data;
        cfg_m = cfg;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: leds=%h expected %h (edge %0d)", tag, obs, exp, n_m);
        end
    endtask

    // One clock: predict from pre-edge model state, advance model, compare #1 after the edge.
    task automatic step(input string tag);
        logic [15:0] exp;
        exp = model_view(debug_sel);
        model_edge();
        @(posedge clk);
        #1;
        check(tag, leds, exp);
        data_valid = 1'b0;
        err_valid  = 1'b0;
        err_clear  = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        debug_sel  = 1'b0;
        data       = 8'h00;
        data_valid = 1'b0;
        err        = 6'b000000;
        err_valid  = 1'b0;
        err_clear  = 1'b0;
        cfg        = 8'h00;
        model_reset();

        repeat (10) @(posedge clk);
        #1;
        check("reset", leds, 16'h0000);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) step("idle");
        check("idle_dark", leds, 16'h0000);

        err = 6'b000001; err_valid = 1'b1;
        step("ch0_set");
        for (int i = 0; i < 8; i++) step("ch0_blink");
        err = 6'b000001; err_valid = 1'b1;
        step("ch0_restart");
        for (int i = 0; i < 20; i++) step("ch0_hold");
        check("ch0_steady", leds, 16'h0001);

        err = 6'b000001; err_valid = 1'b1; err_clear = 1'b1;
        step("clear_prio");
        step("clear_prio_out");
        check("ch0_cleared", leds, 16'h0000);

        cfg = 8'h81;
        step("cfg_in");
        step("cfg_out");
        check("cfg_81", leds, 16'h8100);

        err = 6'b000001; err_valid = 1'b1;
        step("ch0_reset_for_dbg");
        debug_sel = 1'b1; data = 8'hAA; data_valid = 1'b1;
        step("dbg_load");
        step("dbg_view");
        check("dbg_active", leds, 16'h80AA);
        err_clear = 1'b1;
        step("dbg_clear");
        step("dbg_after_clear");
        check("dbg_idle", leds, 16'h00AA);

        debug_sel = 1'b0;
        err = 6'b110100; err_valid = 1'b0;
        step("err_ignored");
        step("err_ignored");
        step("err_ignored");
        err_valid = 1'b1;
        step("multi_set");
        for (int i = 0; i < 10; i++) step("multi_blink");

        // Asynchronous reset in the middle of a blink window.
        #1;
        rst = 1'b0;
        #1;
        check("async_rst", leds, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", leds, 16'h0000);
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst");

        for (int k = 0; k < 400; k++) begin
            err        = 6'($urandom_range(0, 63));
            err_valid  = ($urandom_range(0, 9) == 0);
            err_clear  = ($urandom_range(0, 59) == 0);
            data       = 8'($urandom_range(0, 255));
            data_valid = ($urandom_range(0, 3) == 0);
            cfg        = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) debug_sel = ~debug_sel;
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
